// File: rtl/alu_pkg.sv
// Shared ALU definitions: the adder FSM state type and sizing helpers for
// digit-serial datapaths.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A one-digit operation still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple adder built from fulladder cells; also
// exposes the carry into its top bit so the caller can derive signed overflow.
module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout     = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];
endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/multicycle_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock with the ripple
// carry held in a register. Subtraction is enabled by MULTICYCLE_ADDER_SUB_EN.
module multicycle_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);
    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready/valid come from registered state only, and a
    // producer holds its data stable while valid is high and ready is low.
    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carryout;
    logic               r_overflow;
    logic               r_zero;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcout;
    logic               w_dcmsb;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_last;

`ifdef MULTICYCLE_ADDER_SUB_EN
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_in       = b;
    assign w_cin_in     = cin;
`endif

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a        (r_a[DIGIT-1:0]),
        .b        (r_b[DIGIT-1:0]),
        .cin      (r_carry),
        .sum      (w_dsum),
        .cout     (w_dcout),
        .c_msb_in (w_dcmsb)
    );

    assign w_last = (r_cnt == LAST_CNT);

    // Result fills from the top, so after NDIG digits the LSB digit sits at bit 0.
    always_comb begin
        w_sum_next = r_sum >> DIGIT;
        w_sum_next[WIDTH-1 -: DIGIT] = w_dsum;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_sum   <= w_sum_next;
                    if (w_last) begin
                        r_carryout <= w_dcout;
                        r_overflow <= w_dcmsb ^ w_dcout;
                        r_zero     <= (w_sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign carryout  = r_carryout;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: a 32/4 instance and an 8/8 instance, checked
// against an arithmetic reference model through an expected-result queue.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        carryout, overflow, zero;
    logic [1:0]  dbg_state;

    logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready;
    logic [7:0]  s_a, s_b, s_sum;
    logic        s_carryout, s_overflow, s_zero;
    logic [1:0]  s_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];
    logic [10:0] exp8_q[$];

    multicycle_adder #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carryout(carryout),
        .overflow(overflow), .zero(zero), .dbg_state(dbg_state)
    );

    multicycle_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .sum(s_sum), .carryout(s_carryout),
        .overflow(s_overflow), .zero(s_zero), .dbg_state(s_dbg_state)
    );

    // Reference: {zero, overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [34:0] model32(input logic [31:0] ia, input logic [31:0] ib,
                                            input logic ici, input logic isub);
        logic [31:0] be;
        logic        c0;
        logic [32:0] r;
        logic        ov;
        be = ib;
        c0 = ici;
`ifdef MULTICYCLE_ADDER_SUB_EN
        if (isub) begin
            be = ~ib;
            c0 = 1'b1;
        end
`endif
        r  = {1'b0, ia} + {1'b0, be} + 33'(c0);
        ov = (ia[31] == be[31]) && (r[31] != ia[31]);
        return {r[31:0] == 32'd0, ov, r[32], r[31:0]};
    endfunction

    function automatic logic [10:0] model8(input logic [7:0] ia, input logic [7:0] ib,
                                           input logic ici, input logic isub);
        logic [7:0] be;
        logic       c0;
        logic [8:0] r;
        logic       ov;
        be = ib;
        c0 = ici;
`ifdef MULTICYCLE_ADDER_SUB_EN
        if (isub) begin
            be = ~ib;
            c0 = 1'b1;
        end
`endif
        r  = {1'b0, ia} + {1'b0, be} + 9'(c0);
        ov = (ia[7] == be[7]) && (r[7] != ia[7]);
        return {r[7:0] == 8'd0, ov, r[8], r[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out32(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          input logic ici, input logic isub);
        int cyc;
        logic [34:0] e;
        exp_q.push_back(model32(ia, ib, ici, isub));
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        a = ia; b = ib; cin = ici; sub = isub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out32(cyc);
        chk("latency32", 64'(cyc), 64'd8);
        e = exp_q.pop_front();
        chk("result32", 64'({zero, overflow, carryout, sum}), 64'(e));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
        chk("result32_held", 64'({zero, overflow, carryout, sum}), 64'(e));
    endtask

    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib,
                           input logic ici, input logic isub);
        int cyc;
        logic [10:0] e;
        exp8_q.push_back(model8(ia, ib, ici, isub));
        s_a = ia; s_b = ib; s_cin = ici; s_sub = isub; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("latency8", 64'(cyc), 64'd1);
        e = exp8_q.pop_front();
        chk("result8", 64'({s_zero, s_overflow, s_carryout, s_sum}), 64'(e));
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("in_ready8_after_hs", 64'(s_in_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        logic [34:0] e;
        in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
        s_in_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0; s_out_ready = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'({zero, overflow, carryout, sum}), 64'd0);
        chk("rst8_in_ready", 64'(s_in_ready), 64'd1);
        chk("rst8_result", 64'({s_out_valid, s_zero, s_overflow, s_carryout, s_sum}), 64'd0);

        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        chk("wrap_const", 64'({zero, overflow, carryout, sum}), 64'h4_0000_0000 | 64'h1_0000_0000);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        chk("ovf_const", 64'({zero, overflow, carryout, sum}), 64'h2_8000_0000);
        run_op(32'd5, 32'd7, 1'b0, 1'b1);
`ifdef MULTICYCLE_ADDER_SUB_EN
        chk("sub_const", 64'({zero, overflow, carryout, sum}), 64'h0_FFFF_FFFE);
`else
        chk("sub_const", 64'({zero, overflow, carryout, sum}), 64'd12);
`endif

        for (int i = 0; i < 16; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Consumer stalls in DONE while new operands are offered.
        exp_q.push_back(model32(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0));
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out32(cyc);
        chk("stall_latency", 64'(cyc), 64'd8);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; in_valid = 1'b1;
            tick();
            chk("stall_result", 64'({zero, overflow, carryout, sum}), 64'(e));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("stall_no_extra_out", 64'(out_valid), 64'd0);
        chk("stall_idle", 64'(in_ready), 64'd1);

        // Reset during the third RUN cycle abandons the operation.
        a = 32'hAAAA_0000; b = 32'h0000_5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'({zero, overflow, carryout, sum}), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("midrst_no_out", 64'(out_valid), 64'd0);
        run_op(32'd3, 32'd4, 1'b0, 1'b0);
        chk("after_rst_sum", 64'(sum), 64'd7);

        // Single-digit configuration.
        run_op8(8'h80, 8'h80, 1'b0, 1'b0);
        chk("w8_const", 64'({s_zero, s_overflow, s_carryout, s_sum}), 64'h700);
        for (int i = 0; i < 8; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
